// File: rtl/sr_debounce_ctrl.sv
// ============================================================================
// Module   : sr_debounce_ctrl
// Brief    : Debounces raw set/reset push-buttons and sequences one gated
//            write (data, enable strobe, hold) into an active-high SR latch.
//            Build option: SR_DEBOUNCE_SYNC_EN selects a 2-flop synchroniser
//            ahead of each debouncer; when undefined a single sampling
//            register is used instead.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sr_debounce_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_in,
    input  logic rst_in,
    output logic s,
    output logic r,
    output logic en,
    output logic busy,
    output logic conflict
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Channel 0 is set, channel 1 is reset.
    logic [1:0] w_raw;
    logic [1:0] w_rise;
    logic [1:0] w_pend_clr;

    state_t     state_q;
    logic [1:0] pend_q;
    logic       s_q;
    logic       r_q;
    logic       en_q;
    logic       busy_q;
    logic       conflict_q;

    assign w_raw = {rst_in, set_in};

    for (genvar i = 0; i < 2; i++) begin : g_chan
        logic             d_q;
        logic             stable_q;
        logic [CNT_W-1:0] cnt_q;

`ifdef SR_DEBOUNCE_SYNC_EN
        logic             meta_q;

        // Two-flop synchroniser for the asynchronous button level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                meta_q <= 1'b0;
                d_q    <= 1'b0;
            end else begin
                meta_q <= w_raw[i];
                d_q    <= meta_q;
            end
        end
`else
        // Single sampling register for clock-aligned stimulus.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_q <= 1'b0;
            end else begin
                d_q <= w_raw[i];
            end
        end
`endif

        // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else if (d_q == stable_q) begin
                cnt_q    <= '0;
            end else if (cnt_q == C_CNT_MAX) begin
                stable_q <= d_q;
                cnt_q    <= '0;
            end else begin
                cnt_q    <= cnt_q + 1'b1;
            end
        end

        // A press is the cycle in which the debounced level is about to go high.
        assign w_rise[i] = d_q && !stable_q && (cnt_q == C_CNT_MAX);
    end

    // Pending flags consumed this cycle: the launched one, or both on a conflict.
    always_comb begin
        w_pend_clr = 2'b00;
        if (state_q == ST_IDLE) begin
            w_pend_clr = pend_q;
        end
    end

    // Write sequencer with registered latch controls and request bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pend_q     <= 2'b00;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= 1'b0;
            pend_q     <= (pend_q & ~w_pend_clr) | w_rise;
            case (state_q)
                ST_IDLE: begin
                    if (pend_q == 2'b11) begin
                        conflict_q <= 1'b1;
                    end else if (pend_q[0]) begin
                        state_q <= ST_SETUP;
                        s_q     <= 1'b1;
                        r_q     <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (pend_q[1]) begin
                        state_q <= ST_SETUP;
                        s_q     <= 1'b0;
                        r_q     <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_STROBE;
                    en_q    <= 1'b1;
                end
                ST_STROBE: begin
                    state_q <= ST_HOLD;
                    en_q    <= 1'b0;
                end
                ST_HOLD: begin
                    state_q <= ST_IDLE;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign en       = en_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;

endmodule

`default_nettype wire
